// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge
//   Turns the core's SRAM-style instruction and data requests into
//   single-beat AXI transactions, one outstanding at a time, and stalls
//   the core until every latched request has been served.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   inst_sram_en/addr/rdata     instruction fetch request and result
//   data_sram_en/wen/addr/wdata data access request (wen==0 is a read)
//   data_sram_rdata             load result
//   cpu_stall                   core holds PC and requests while high
//   ar*/r*/aw*/w*/b*            AXI read and write channels
//
// DATA_FIRST selects which side wins when both requests arrive together.
module cpu_axi_bridge #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        cpu_stall,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW_W = 3'd3,
    B    = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_r;
  logic        inst_pend_r;
  logic        data_pend_r;
  logic [31:0] inst_addr_r;
  logic [31:0] data_addr_r;
  logic [3:0]  data_wen_r;
  logic [31:0] data_wdata_r;
  logic        rd_is_data_r;   // the read in flight belongs to the data side
  logic        aw_done_r;
  logic        w_done_r;

  logic        pick_data_s;
  logic        aw_now_s;
  logic        w_now_s;
  logic        stall_s;

  // Arbitration of same-cycle requests and write-channel completion tracking
  always_comb begin
    pick_data_s = data_sram_en & (DATA_FIRST | ~inst_sram_en);
    aw_now_s    = aw_done_r | (awvalid & awready);
    w_now_s     = w_done_r  | (wvalid & wready);
  end

  // Stall decode: IDLE term is combinational so the request cycle itself stalls
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:           stall_s = inst_sram_en | data_sram_en;
      AR, R, AW_W, B: stall_s = 1'b1;
      DONE:           stall_s = 1'b0;
      default:        stall_s = 1'b0;
    endcase
  end

  assign cpu_stall = stall_s;

  // Bridge FSM with registered AXI outputs and captured read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= IDLE;
      inst_pend_r     <= 1'b0;
      data_pend_r     <= 1'b0;
      inst_addr_r     <= 32'h0;
      data_addr_r     <= 32'h0;
      data_wen_r      <= 4'h0;
      data_wdata_r    <= 32'h0;
      rd_is_data_r    <= 1'b0;
      aw_done_r       <= 1'b0;
      w_done_r        <= 1'b0;
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
      araddr          <= 32'h0;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      awaddr          <= 32'h0;
      awvalid         <= 1'b0;
      wdata           <= 32'h0;
      wstrb           <= 4'h0;
      wvalid          <= 1'b0;
      bready          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (inst_sram_en || data_sram_en) begin
            inst_pend_r  <= inst_sram_en;
            data_pend_r  <= data_sram_en;
            inst_addr_r  <= inst_sram_addr;
            data_addr_r  <= data_sram_addr;
            data_wen_r   <= data_sram_wen;
            data_wdata_r <= data_sram_wdata;
            if (pick_data_s && (data_sram_wen != 4'h0)) begin
              state_r   <= AW_W;
              awaddr    <= data_sram_addr;
              awvalid   <= 1'b1;
              wdata     <= data_sram_wdata;
              wstrb     <= data_sram_wen;
              wvalid    <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
            end else if (pick_data_s) begin
              state_r      <= AR;
              araddr       <= data_sram_addr;
              arvalid      <= 1'b1;
              rd_is_data_r <= 1'b1;
            end else begin
              state_r      <= AR;
              araddr       <= inst_sram_addr;
              arvalid      <= 1'b1;
              rd_is_data_r <= 1'b0;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_r <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (rd_is_data_r) begin
              data_sram_rdata <= rdata;
              data_pend_r     <= 1'b0;
              if (inst_pend_r) begin
                state_r      <= AR;
                araddr       <= inst_addr_r;
                arvalid      <= 1'b1;
                rd_is_data_r <= 1'b0;
              end else begin
                state_r <= DONE;
              end
            end else begin
              inst_sram_rdata <= rdata;
              inst_pend_r     <= 1'b0;
              // A data request left behind the fetch may be a store, which
              // must take the write path rather than a read.
              if (data_pend_r && (data_wen_r != 4'h0)) begin
                state_r   <= AW_W;
                awaddr    <= data_addr_r;
                awvalid   <= 1'b1;
                wdata     <= data_wdata_r;
                wstrb     <= data_wen_r;
                wvalid    <= 1'b1;
                aw_done_r <= 1'b0;
                w_done_r  <= 1'b0;
              end else if (data_pend_r) begin
                state_r      <= AR;
                araddr       <= data_addr_r;
                arvalid      <= 1'b1;
                rd_is_data_r <= 1'b1;
              end else begin
                state_r <= DONE;
              end
            end
          end
        end
        AW_W: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_now_s && w_now_s) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            bready    <= 1'b1;
            state_r   <= B;
          end else begin
            aw_done_r <= aw_now_s;
            w_done_r  <= w_now_s;
          end
        end
        B: begin
          if (bvalid) begin
            bready      <= 1'b0;
            data_pend_r <= 1'b0;
            if (inst_pend_r) begin
              state_r      <= AR;
              araddr       <= inst_addr_r;
              arvalid      <= 1'b1;
              rd_is_data_r <= 1'b0;
            end else begin
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Self-checking bench for cpu_axi_bridge: an AXI slave with programmable
// ready/valid delays logs every completed transaction; a transaction-level
// model predicts the ordered transaction list and the rdata outputs.
module tb_cpu_axi_bridge;

  localparam bit DF = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        cpu_stall;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  cpu_axi_bridge #(.DATA_FIRST(DF)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .cpu_stall(cpu_stall),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } txn_t;

  txn_t obs_q[$];

  // slave configuration and bookkeeping
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int n_b = 0, aw_only = 0;

  // model state: what the rdata outputs should currently hold
  logic [31:0] m_ird = 32'h0;
  logic [31:0] m_drd = 32'h0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'hBFC0_0000) mem_val = 32'h2401_0001;
    else mem_val = a ^ 32'hA5A5_5A5A;
  endfunction

  // AXI slave: acts shortly after each rising edge, so everything it drives
  // is stable by the next edge.
  initial begin : slave
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit rd_pend, aw_got, w_got;
    logic [31:0] rd_addr, a_hold, aw_hold, aw_a, w_hold, w_d;
    logic [3:0] s_hold, w_s;
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_ara, p_awa, p_wd;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    rd_addr = 32'h0; a_hold = 32'h0; aw_hold = 32'h0; aw_a = 32'h0;
    w_hold = 32'h0; w_d = 32'h0; s_hold = 4'h0; w_s = 4'h0;
    p_arv = 1'b0; p_arr = 1'b0; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
    p_ara = 32'h0; p_awa = 32'h0; p_wd = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        p_arv = 1'b0; p_arr = 1'b0; p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
      end else begin
        // handshakes completed at the edge just passed
        if (arready) begin
          arready = 1'b0; rd_pend = 1'b1; rd_addr = a_hold; r_cnt = 0;
          obs_q.push_back('{1'b0, a_hold, 4'h0, 32'h0});
        end
        if (rvalid) begin
          rvalid = 1'b0; rd_pend = 1'b0;
        end
        if (awready) begin
          awready = 1'b0; aw_got = 1'b1; aw_a = aw_hold;
        end
        if (wready) begin
          wready = 1'b0; w_got = 1'b1; w_d = w_hold; w_s = s_hold;
        end
        if (bvalid) begin
          bvalid = 1'b0; n_b++;
          obs_q.push_back('{1'b1, aw_a, w_s, w_d});
          aw_got = 1'b0; w_got = 1'b0;
        end
        // valids and payloads must hold until their ready
        if (p_arv && !p_arr) begin
          chk32("arvalid_hold", 32'(arvalid), 32'd1);
          chk32("araddr_hold", araddr, p_ara);
        end
        if (p_awv && !p_awr) begin
          chk32("awvalid_hold", 32'(awvalid), 32'd1);
          chk32("awaddr_hold", awaddr, p_awa);
        end
        if (p_wv && !p_wr) begin
          chk32("wvalid_hold", 32'(wvalid), 32'd1);
          chk32("wdata_hold", wdata, p_wd);
        end
        // ready outputs idle outside their phases
        if (!rd_pend) chk32("rready_idle", 32'(rready), 32'd0);
        if (!(aw_got && w_got)) chk32("bready_idle", 32'(bready), 32'd0);
        // raise readies / responses after the programmed delays
        if (arvalid && !rd_pend) begin
          if (ar_cnt >= ar_dly) begin arready = 1'b1; a_hold = araddr; ar_cnt = 0; end
          else ar_cnt++;
        end
        if (rd_pend && rready) begin
          if (r_cnt >= r_dly) begin rvalid = 1'b1; rdata = mem_val(rd_addr); end
          else r_cnt++;
        end
        if (awvalid && !aw_got) begin
          if (aw_cnt >= aw_dly) begin awready = 1'b1; aw_hold = awaddr; aw_cnt = 0; end
          else aw_cnt++;
        end
        if (wvalid && !w_got) begin
          if (w_cnt >= w_dly) begin wready = 1'b1; w_hold = wdata; s_hold = wstrb; w_cnt = 0; end
          else w_cnt++;
        end
        if (aw_got && w_got && bready) begin
          if (b_cnt >= b_dly) begin bvalid = 1'b1; b_cnt = 0; end
          else b_cnt++;
        end
        if (awvalid && !wvalid) aw_only++;
        p_arv = arvalid; p_arr = arready; p_ara = araddr;
        p_awv = awvalid; p_awr = awready; p_awa = awaddr;
        p_wv = wvalid; p_wr = wready; p_wd = wdata;
      end
    end
  end

  task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
    ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  task automatic clear_req();
    inst_sram_en = 1'b0; inst_sram_addr = 32'h0;
    data_sram_en = 1'b0; data_sram_wen = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
  endtask

  task automatic recover();
    rst = 1'b0; clear_req();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_ird = 32'h0; m_drd = 32'h0;
  endtask

  // waits (bounded) for cpu_stall to fall; ends on a negedge
  task automatic wait_unstall(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!cpu_stall) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout actual=stalled required=done_within_200", name);
    end
  endtask

  // issue one request set, hold it while stalled, then drop it in DONE
  task automatic run_req(input bit ie, input logic [31:0] ia, input bit de,
                         input logic [3:0] wen, input logic [31:0] da,
                         input logic [31:0] wd, output bit ok);
    @(negedge clk);
    obs_q.delete();
    inst_sram_en = ie; inst_sram_addr = ia;
    data_sram_en = de; data_sram_wen = wen;
    data_sram_addr = da; data_sram_wdata = wd;
    #1;
    chk32("stall_on_request", 32'(cpu_stall), 32'd1);
    wait_unstall("req", ok);
    clear_req();
  endtask

  // transaction-level prediction: ordered transactions plus rdata outputs
  task automatic model_check(input bit ie, input logic [31:0] ia, input bit de,
                             input logic [3:0] wen, input logic [31:0] da,
                             input logic [31:0] wd);
    txn_t e_q[$];
    txn_t ti, td;
    int n;
    ti = '{1'b0, ia, 4'h0, 32'h0};
    if (wen != 4'h0) td = '{1'b1, da, wen, wd};
    else td = '{1'b0, da, 4'h0, 32'h0};
    if (ie && de) begin
      if (DF) begin e_q.push_back(td); e_q.push_back(ti); end
      else begin e_q.push_back(ti); e_q.push_back(td); end
    end else if (ie) e_q.push_back(ti);
    else e_q.push_back(td);
    if (ie) m_ird = mem_val(ia);
    if (de && (wen == 4'h0)) m_drd = mem_val(da);
    chk32("txn_count", 32'(obs_q.size()), 32'(e_q.size()));
    n = (obs_q.size() < e_q.size()) ? obs_q.size() : e_q.size();
    for (int i = 0; i < n; i++) begin
      chk32("txn_kind", 32'(obs_q[i].is_wr), 32'(e_q[i].is_wr));
      chk32("txn_addr", obs_q[i].addr, e_q[i].addr);
      if (e_q[i].is_wr) begin
        chk32("txn_wstrb", 32'(obs_q[i].strb), 32'(e_q[i].strb));
        chk32("txn_wdata", obs_q[i].data, e_q[i].data);
      end
    end
    chk32("inst_rdata", inst_sram_rdata, m_ird);
    chk32("data_rdata", data_sram_rdata, m_drd);
  endtask

  typedef struct {
    bit          ie;
    logic [31:0] ia;
    bit          de;
    logic [3:0]  wen;
    logic [31:0] da;
    logic [31:0] wd;
    int          ard, rd, awd, wdl, bd;
    int          exp_ntx;
    bit          exp_first_wr;
    logic [31:0] exp_first_addr;
    logic [3:0]  exp_first_strb;
    logic [31:0] exp_ird;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    bit ok;
    bit ie, de;
    logic [31:0] ia, da, wd;
    logic [3:0] wen;
    int b0, n0;

    vecs[0] = '{1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0,
                1, 2, 0, 0, 0, 1, 1'b0, 32'hBFC0_0000, 4'h0, 32'h2401_0001};
    vecs[1] = '{1'b1, 32'hBFC0_0000, 1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF,
                0, 1, 1, 2, 1, 2, 1'b1, 32'h8000_1000, 4'hF, 32'h2401_0001};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 4'b0010, 32'h8000_0001, 32'h1122_3344,
                0, 0, 0, 0, 0, 1, 1'b1, 32'h8000_0001, 4'b0010, 32'h2401_0001};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0040, 32'h0,
                2, 0, 0, 0, 0, 1, 1'b0, 32'h0000_0040, 4'h0, 32'h2401_0001};
    vecs[4] = '{1'b1, 32'h0000_0100, 1'b1, 4'h0, 32'h0000_0200, 32'h0,
                0, 3, 0, 0, 0, 2, 1'b0, 32'h0000_0200, 4'h0, 32'hA5A5_5B5A};

    rst = 1'b0;
    clear_req();
    repeat (3) @(negedge clk);
    chk32("rst_arvalid", 32'(arvalid), 32'd0);
    chk32("rst_awvalid", 32'(awvalid), 32'd0);
    chk32("rst_wvalid", 32'(wvalid), 32'd0);
    chk32("rst_rready", 32'(rready), 32'd0);
    chk32("rst_bready", 32'(bready), 32'd0);
    chk32("rst_stall", 32'(cpu_stall), 32'd0);
    chk32("rst_inst_rdata", inst_sram_rdata, 32'h0);
    chk32("rst_data_rdata", data_sram_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk32("idle_no_stall", 32'(cpu_stall), 32'd0);

    // table-driven directed vectors
    for (int i = 0; i < 5; i++) begin
      set_dly(vecs[i].ard, vecs[i].rd, vecs[i].awd, vecs[i].wdl, vecs[i].bd);
      run_req(vecs[i].ie, vecs[i].ia, vecs[i].de, vecs[i].wen, vecs[i].da, vecs[i].wd, ok);
      chk32("vec_ntx", 32'(obs_q.size()), 32'(vecs[i].exp_ntx));
      if (obs_q.size() > 0) begin
        chk32("vec_first_kind", 32'(obs_q[0].is_wr), 32'(vecs[i].exp_first_wr));
        chk32("vec_first_addr", obs_q[0].addr, vecs[i].exp_first_addr);
        chk32("vec_first_strb", 32'(obs_q[0].strb), 32'(vecs[i].exp_first_strb));
      end
      chk32("vec_inst_rdata", inst_sram_rdata, vecs[i].exp_ird);
      model_check(vecs[i].ie, vecs[i].ia, vecs[i].de, vecs[i].wen, vecs[i].da, vecs[i].wd);
      if (!ok) recover();
    end

    // wready early, awready late: wvalid drops alone, one B
    set_dly(0, 0, 3, 0, 1);
    aw_only = 0;
    b0 = n_b;
    run_req(1'b0, 32'h0, 1'b1, 4'hF, 32'h8000_2000, 32'hCAFE_F00D, ok);
    chk32("aw_held_after_w", 32'(aw_only >= 1), 32'd1);
    chk32("single_b", 32'(n_b - b0), 32'd1);
    model_check(1'b0, 32'h0, 1'b1, 4'hF, 32'h8000_2000, 32'hCAFE_F00D);
    if (!ok) recover();

    // DONE ignores a still-asserted request; it is reissued after a bubble
    set_dly(0, 1, 0, 0, 0);
    @(negedge clk);
    obs_q.delete();
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_0300;
    wait_unstall("done_hold", ok);
    chk32("done_one_read", 32'(obs_q.size()), 32'd1);
    @(negedge clk);
    chk32("bubble_stall", 32'(cpu_stall), 32'd1);
    chk32("bubble_no_ar", 32'(arvalid), 32'd0);
    wait_unstall("reissue", ok);
    clear_req();
    chk32("reissue_reads", 32'(obs_q.size()), 32'd2);
    m_ird = mem_val(32'h0000_0300);
    chk32("reissue_rdata", inst_sram_rdata, m_ird);
    if (!ok) recover();

    // reset while waiting in R: abandon, no replay, then a clean fetch
    set_dly(0, 30, 0, 0, 0);
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_0400;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rready) begin ok = 1'b1; break; end
    end
    chk32("reach_r_state", 32'(ok), 32'd1);
    rst = 1'b0;
    clear_req();
    #1;
    chk32("mid_rst_arvalid", 32'(arvalid), 32'd0);
    chk32("mid_rst_rready", 32'(rready), 32'd0);
    chk32("mid_rst_awvalid", 32'(awvalid), 32'd0);
    chk32("mid_rst_wvalid", 32'(wvalid), 32'd0);
    chk32("mid_rst_bready", 32'(bready), 32'd0);
    chk32("mid_rst_stall", 32'(cpu_stall), 32'd0);
    chk32("mid_rst_inst_rdata", inst_sram_rdata, 32'h0);
    chk32("mid_rst_data_rdata", data_sram_rdata, 32'h0);
    m_ird = 32'h0; m_drd = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    obs_q.delete();
    repeat (3) @(negedge clk);
    chk32("no_replay_ar", 32'(arvalid), 32'd0);
    chk32("no_replay_txn", 32'(obs_q.size()), 32'd0);
    chk32("no_replay_stall", 32'(cpu_stall), 32'd0);
    set_dly(1, 1, 0, 0, 0);
    run_req(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0, ok);
    model_check(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0);
    if (!ok) recover();

    // randomized requests against the model
    for (int k = 0; k < 40; k++) begin
      n0 = $urandom_range(1, 3);
      ie = n0[0];
      de = n0[1];
      ia = $urandom() & 32'hFFFF_FFFC;
      da = $urandom();
      wd = $urandom();
      if ($urandom_range(0, 1) == 1) wen = 4'($urandom_range(1, 15));
      else wen = 4'h0;
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      run_req(ie, ia, de, wen, da, wd, ok);
      model_check(ie, ia, de, wen, da, wd);
      if (!ok) recover();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
